// File: rtl/wb_activity_leds_pkg.sv
// rtl/wb_activity_leds_pkg.sv - shared types for the Wishbone activity LED monitor
package wb_activity_pkg;

    localparam int DAT_W = 32;

    typedef enum logic [1:0] {IDLE, PEND, ERR} state_t;

    typedef enum logic [1:0] {VIEW_CNT, VIEW_ACT, VIEW_ERR, VIEW_DAT} view_t;

    typedef struct packed {
        logic             stb;
        logic             we;
        logic [DAT_W-1:0] dat;
    } wb_ctrl_t;

    typedef struct packed {
        logic             ack;
        logic [DAT_W-1:0] dat;
    } wb_peri_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_activity_leds_if.sv
// rtl/wb_activity_leds_if.sv - bundle of snooped Wishbone controller/peripheral links
interface wb_activity_leds_if #(
    parameter int pChannels = 1
);
    import wb_activity_pkg::*;

    wb_ctrl_t wb_c [pChannels];
    wb_peri_t wb_p [pChannels];

    modport master (output wb_c, output wb_p);
    modport slave  (input  wb_c, input  wb_p);

endinterface

// File: rtl/wb_activity_leds_chan.sv
// rtl/wb_activity_leds_chan.sv - per-link transfer counter, stall detector, stretcher, snapshot
module wb_chan_monitor
    import wb_activity_pkg::*;
#(
    parameter int pCntW    = 8,
    parameter int pHold    = 2**20,
    parameter int pTimeout = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  wb_ctrl_t         c,
    input  wb_peri_t         p,
    input  logic             clr_err,
    output logic [pCntW-1:0] cnt,
    output logic             pend,
    output logic             act,
    output logic             err,
    output logic             last_we,
    output logic [DAT_W-1:0] last_dat
);

    localparam int TW = $clog2(pTimeout);
    localparam int HW = $clog2(pHold + 1);
    localparam logic [TW-1:0] TMAX  = TW'(pTimeout - 1);
    localparam logic [HW-1:0] HLOAD = HW'(pHold);

    state_t        state;
    logic [TW-1:0] timer;
    logic [HW-1:0] hold;

    // An ack arriving on the expiry cycle is checked first, so it wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (c.stb && p.ack) begin
                        cnt <= cnt + 1'b1;
                    end else if (c.stb) begin
                        state <= PEND;
                        timer <= '0;
                    end
                end
                PEND: begin
                    if (p.ack) begin
                        state <= IDLE;
                        cnt   <= cnt + 1'b1;
                    end else if (timer == TMAX) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ERR: begin
                    if (clr_err) begin
                        state <= IDLE;
                        err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold <= '0;
        end else if (c.stb || p.ack) begin
            hold <= HLOAD;
        end else if (hold != '0) begin
            hold <= hold - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_dat <= '0;
            last_we  <= 1'b0;
        end else if (c.stb && c.we) begin
            last_dat <= c.dat;
            last_we  <= 1'b1;
        end else if (p.ack && !c.we) begin
            last_dat <= p.dat;
            last_we  <= 1'b0;
        end
    end

    assign pend = (state == PEND);
    assign act  = (hold != '0);

endmodule

// File: rtl/wb_activity_leds.sv
// rtl/wb_activity_leds.sv - multi-channel Wishbone activity monitor with selectable LED view
module wb_activity_leds
    import wb_activity_pkg::*;
#(
    parameter int pChannels = 1,
    parameter int pLeds     = 8,
    parameter int pCntW     = 8,
    parameter int pHold     = 2**20,
    parameter int pTimeout  = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    wb_activity_leds_if.slave               bus,
    input  logic [1:0]                      mode,
    input  logic [sel_w(pChannels)-1:0]     sel,
    input  logic                            clr_err,
    output logic [pLeds-1:0]                leds
);

    localparam int SW = sel_w(pChannels);
    localparam int CW = (pLeds > 4) ? pLeds - 4 : 1;

    logic [pCntW-1:0]     cnt_a [pChannels];
    logic [DAT_W-1:0]     dat_a [pChannels];
    logic [pChannels-1:0] pend_v, act_v, err_v, we_v;

    for (genvar i = 0; i < pChannels; i++) begin : g_chan
        wb_chan_monitor #(
            .pCntW    (pCntW),
            .pHold    (pHold),
            .pTimeout (pTimeout)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .c        (bus.wb_c[i]),
            .p        (bus.wb_p[i]),
            .clr_err  (clr_err),
            .cnt      (cnt_a[i]),
            .pend     (pend_v[i]),
            .act      (act_v[i]),
            .err      (err_v[i]),
            .last_we  (we_v[i]),
            .last_dat (dat_a[i])
        );
    end

    logic [pCntW-1:0] cnt_s;
    logic [DAT_W-1:0] dat_s;
    logic             pend_s, we_s;

    // Channel 0 is the fallback, which also covers out-of-range selects.
    always_comb begin
        cnt_s  = cnt_a[0];
        dat_s  = dat_a[0];
        pend_s = pend_v[0];
        we_s   = we_v[0];
        for (int i = 1; i < pChannels; i++) begin
            if (sel == SW'(i)) begin
                cnt_s  = cnt_a[i];
                dat_s  = dat_a[i];
                pend_s = pend_v[i];
                we_s   = we_v[i];
            end
        end
    end

    logic [3:0] flags;
    assign flags = {pend_s, we_s, we_s & (|dat_s), ~we_s & (|dat_s)};

    always_ff @(posedge clk) begin
        if (!rst) begin
            leds <= '0;
        end else begin
            case (view_t'(mode))
                VIEW_CNT: leds <= pLeds'({CW'(cnt_s), flags});
                VIEW_ACT: leds <= pLeds'(act_v);
                VIEW_ERR: leds <= pLeds'(err_v);
                VIEW_DAT: leds <= pLeds'(dat_s);
                default:  leds <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_activity_leds.sv
// tb/tb_wb_activity_leds.sv - directed scoreboard bench for wb_activity_leds
module tb_wb_activity_leds;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       clr_err;
    logic [7:0] leds;

    wb_activity_leds_if #(.pChannels(3)) bus ();

    wb_activity_leds #(
        .pChannels (3),
        .pLeds     (8),
        .pCntW     (4),
        .pHold     (5),
        .pTimeout  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mode    (mode),
        .sel     (sel),
        .clr_err (clr_err),
        .leds    (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_leds(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            assert (leds === e.val) else begin
                n_fail++;
                $error("FAIL %s: leds=%h expected %h", e.tag, leds, e.val);
            end
        end
    endtask

    task automatic ctl(input int ch, input logic stb, input logic we, input logic ack);
        bus.wb_c[ch].stb = stb;
        bus.wb_c[ch].we  = we;
        bus.wb_p[ch].ack = ack;
    endtask

    function automatic logic [7:0] leds0(input logic [3:0] cnt, input logic pend,
                                         input logic we, input logic nz);
        return {cnt, pend, we, we & nz, ~we & nz};
    endfunction

    logic [3:0] m_cnt;
    logic       m_we, m_nz;

    initial begin
        for (int i = 0; i < 3; i++) begin
            bus.wb_c[i] = '0;
            bus.wb_p[i] = '0;
        end
        rst = 1'b0; mode = 2'd0; sel = 2'd0; clr_err = 1'b0;

        // reset with stb active
        ctl(0, 1, 0, 0);
        expect_leds("rst_leds", 8'h00); tick();
        mode = 2'd2;
        expect_leds("rst_err", 8'h00); tick();
        rst = 1'b1; mode = 2'd0; ctl(0, 0, 0, 0);
        expect_leds("rst_cnt", 8'h00); tick();

        // write with ack three cycles later
        bus.wb_c[0].dat = 32'h5A;
        ctl(0, 1, 1, 0);
        expect_leds("t2_pre", 8'h00); tick();
        expect_leds("t2_pend", 8'h0E); tick();
        tick();
        ctl(0, 1, 1, 1);
        expect_leds("t2_pend2", 8'h0E); tick();
        ctl(0, 0, 0, 0);
        expect_leds("t2_done", 8'h16); tick();

        // stall until timeout, then clear
        mode = 2'd2;
        ctl(0, 1, 0, 0);
        for (int k = 0; k <= 8; k++) begin
            expect_leds($sformatf("t3_noerr%0d", k), 8'h00); tick();
        end
        ctl(0, 0, 0, 0);
        expect_leds("t3_err", 8'h01); tick();
        clr_err = 1'b1;
        expect_leds("t3_clr_hold", 8'h01); tick();
        clr_err = 1'b0;
        expect_leds("t3_cleared", 8'h00); tick();

        // back-to-back reads until the counter wraps
        mode = 2'd0;
        bus.wb_p[0].dat = 32'h0;
        m_cnt = 4'd1; m_we = 1'b1; m_nz = 1'b1;
        ctl(0, 1, 0, 1);
        for (int k = 0; k < 15; k++) begin
            expect_leds($sformatf("t4_run%0d", k), leds0(m_cnt, 1'b0, m_we, m_nz));
            tick();
            m_cnt = m_cnt + 4'd1; m_we = 1'b0; m_nz = 1'b0;
        end
        ctl(0, 0, 0, 0);
        expect_leds("t4_wrap", 8'h00); tick();

        // ack on the expiry cycle is counted, no error
        ctl(0, 1, 0, 0); tick();
        ctl(0, 0, 0, 0);
        for (int k = 0; k < 7; k++) tick();
        ctl(0, 0, 0, 1); tick();
        ctl(0, 0, 0, 0);
        expect_leds("t4_coinc_cnt", 8'h10); tick();
        mode = 2'd2;
        expect_leds("t4_coinc_noerr", 8'h00); tick();

        // activity stretch on ch1, single pulse then retrigger
        mode = 2'd1;
        for (int k = 0; k < 6; k++) tick();
        expect_leds("t5_idle", 8'h00); tick();
        for (int k = 0; k < 8; k++) begin
            ctl(1, k == 0, 0, k == 0);
            expect_leds($sformatf("t5_single%0d", k), (k >= 1 && k <= 5) ? 8'h02 : 8'h00);
            tick();
        end
        for (int k = 0; k < 11; k++) begin
            ctl(1, k == 0 || k == 3, 0, k == 0 || k == 3);
            expect_leds($sformatf("t5_retrig%0d", k), (k >= 1 && k <= 8) ? 8'h02 : 8'h00);
            tick();
        end
        ctl(1, 0, 0, 0);

        // data view and channel select
        mode = 2'd3; sel = 2'd1;
        bus.wb_p[1].dat = 32'hC3;
        bus.wb_c[0].dat = 32'hA5;
        ctl(1, 1, 0, 1);
        ctl(0, 1, 1, 1);
        expect_leds("t6_before", 8'h00); tick();
        ctl(1, 0, 0, 0);
        ctl(0, 0, 0, 0);
        expect_leds("t6_sel1", 8'hC3); tick();
        sel = 2'd3;
        expect_leds("t6_sel_oor", 8'hA5); tick();
        sel = 2'd2;
        expect_leds("t6_sel2", 8'h00); tick();

        // reset while pending drops the request
        mode = 2'd0; sel = 2'd0;
        bus.wb_p[0].dat = 32'h0;
        ctl(0, 1, 0, 0); tick();
        ctl(0, 0, 0, 0); rst = 1'b0; tick();
        rst = 1'b1; ctl(0, 0, 0, 1); tick();
        ctl(0, 0, 0, 0);
        expect_leds("t7_nocount", 8'h00); tick();
        ctl(0, 1, 0, 1); tick();
        ctl(0, 0, 0, 0);
        expect_leds("t7_count", 8'h10); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
